stream_demux_1ton: RTL and testbench



---
 rtl/stream_demux_1ton_if.sv | 30 +++
 rtl/stream_demux_1ton.sv | 115 +++++++++++
 tb/tb_stream_demux_1ton.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1ton_if.sv
// rtl/stream_demux_1ton_if.sv - producer and per-channel consumer bus for stream_demux_1ton
interface stream_demux_1ton_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_last;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_last;
  logic                     err_sel;
  logic                     busy;

  // Environment side: drives beats and consumer readiness.
  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, err_sel, busy
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, err_sel, busy
  );
endinterface

// File: rtl/stream_demux_1ton.sv
// rtl/stream_demux_1ton.sv - packet-locked 1-to-N stream demux with one-deep slot per channel
module stream_demux_1ton #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  stream_demux_1ton_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t                   state_q, state_d;
  logic [SEL_W-1:0]         route_q, route_d;
  logic [NUM_CH-1:0]        out_valid_q, out_valid_d;
  logic [NUM_CH-1:0]        out_last_q, out_last_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
  logic                     err_q, err_d;

  logic                     sel_ok;
  logic                     deliver;
  logic                     in_ready_c;
  logic                     accept;
  logic [SEL_W-1:0]         target;
  logic [NUM_CH-1:0]        load;

  // Resolve the beat's destination and whether that slot can take it this cycle.
  always_comb begin
    sel_ok     = ({1'b0, bus.in_sel} < (SEL_W+1)'(NUM_CH));
    target     = (state_q == PKT) ? route_q : bus.in_sel;
    deliver    = (state_q == PKT) || ((state_q == IDLE) && sel_ok);
    in_ready_c = 1'b1;
    if (deliver) begin
      in_ready_c = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (target == SEL_W'(i)) begin
          in_ready_c = !out_valid_q[i] || bus.out_ready[i];
        end
      end
    end
    accept = bus.in_valid && in_ready_c;
    load   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = accept && deliver && (target == SEL_W'(i));
    end
  end

  // Packet framing: lock the route on the first beat, drop bad-select packets whole.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    err_d   = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (sel_ok) begin
            route_d = bus.in_sel;
            state_d = bus.in_last ? IDLE : PKT;
          end else begin
            err_d   = 1'b1;
            state_d = bus.in_last ? IDLE : DROP;
          end
        end
        PKT, DROP: begin
          if (bus.in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Per-channel slots: a load wins over a drain; payload holds once drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load[i]) begin
        out_valid_d[i]                  = 1'b1;
        out_data_d[i*DATA_W +: DATA_W]  = bus.in_data;
        out_last_d[i]                   = bus.in_last;
      end else if (bus.out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end
  end

  // State, route and slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      route_q     <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.err_sel   = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb/tb_stream_demux_1ton.sv - randomized and directed checks of stream_demux_1ton against a packet-level model
module tb_stream_demux_1ton;
  localparam int DW = 8;
  localparam int NC = 6;
  localparam int SW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic [SW-1:0]    in_sel;
  logic             in_last;
  logic [NC-1:0]    out_ready;
  logic             in_ready;
  logic [NC-1:0]    out_valid;
  logic [NC*DW-1:0] out_data;
  logic [NC-1:0]    out_last;
  logic             err_sel;
  logic             busy;

  stream_demux_1ton_if #(.DATA_W(DW), .NUM_CH(NC), .SEL_W(SW)) bus ();

  assign bus.in_valid  = in_valid;
  assign bus.in_data   = in_data;
  assign bus.in_sel    = in_sel;
  assign bus.in_last   = in_last;
  assign bus.out_ready = out_ready;
  assign in_ready      = bus.in_ready;
  assign out_valid     = bus.out_valid;
  assign out_data      = bus.out_data;
  assign out_last      = bus.out_last;
  assign err_sel       = bus.err_sel;
  assign busy          = bus.busy;

  stream_demux_1ton #(.DATA_W(DW), .NUM_CH(NC), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: is a packet open, where is it going (-1 = discarded), slot contents.
  bit          m_in_pkt;
  int          m_dest;
  bit          m_v [NC];
  logic [DW-1:0] m_d [NC];
  bit          m_l [NC];
  bit          m_err;

  function automatic int beat_dest();
    if (m_in_pkt) return m_dest;
    if (int'(in_sel) < NC) return int'(in_sel);
    return -1;
  endfunction

  function automatic logic exp_ready();
    int d;
    d = beat_dest();
    if (d < 0) return 1'b1;
    return !m_v[d] || out_ready[d];
  endfunction

  function automatic logic [NC-1:0] m_valid_vec();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = m_v[c];
    return v;
  endfunction

  function automatic logic [NC-1:0] m_last_vec();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = m_l[c];
    return v;
  endfunction

  function automatic logic [NC*DW-1:0] m_data_vec();
    logic [NC*DW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = m_d[c];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_pkt <= 1'b0;
      m_dest   <= -1;
      m_err    <= 1'b0;
      for (int c = 0; c < NC; c++) begin
        m_v[c] <= 1'b0;
        m_d[c] <= '0;
        m_l[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NC; c++) if (out_ready[c]) m_v[c] <= 1'b0;
      m_err <= 1'b0;
      if (in_valid && exp_ready()) begin
        if (beat_dest() >= 0) begin
          m_v[beat_dest()] <= 1'b1;
          m_d[beat_dest()] <= in_data;
          m_l[beat_dest()] <= in_last;
        end else if (!m_in_pkt) begin
          m_err <= 1'b1;
        end
        m_in_pkt <= !in_last;
        if (!m_in_pkt) m_dest <= beat_dest();
      end
    end
  end

  int deliv [NC];
  int err_cnt = 0;

  initial for (int c = 0; c < NC; c++) deliv[c] = 0;

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("in_ready",  64'(in_ready),  64'(exp_ready()));
      chk("out_valid", 64'(out_valid), 64'(m_valid_vec()));
      chk("out_data",  64'(out_data),  64'(m_data_vec()));
      chk("out_last",  64'(out_last),  64'(m_last_vec()));
      chk("err_sel",   64'(err_sel),   64'(m_err));
      chk("busy",      64'(busy),      64'(m_in_pkt));
      for (int c = 0; c < NC; c++) if (out_valid[c] && out_ready[c]) deliv[c] <= deliv[c] + 1;
      if (err_sel) err_cnt <= err_cnt + 1;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    chk("send accepted", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] lk [4];
  int w, tw, c0, e0;

  initial begin
    lk[0] = 8'h11; lk[1] = 8'h22; lk[2] = 8'h33; lk[3] = 8'h44;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0; out_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset out_data",  64'(out_data),  64'(0));
    chk("reset out_last",  64'(out_last),  64'(0));
    chk("reset busy",      64'(busy),      64'(0));
    chk("reset err_sel",   64'(err_sel),   64'(0));
    rst = 1'b0;
    run = 1'b1;
    @(posedge clk);
    #1;

    // single-beat routing over every select value
    for (int s = 0; s < 8; s++) begin
      send(8'(8'hA0 + s), 3'(s), 1'b1, w);
      if (s < NC) begin
        chk("single valid", 64'(out_valid), 64'(1) << s);
        chk("single data",  64'(out_data[s*DW +: DW]), 64'(8'hA0 + s));
        chk("single last",  64'(out_last[s]), 64'(1));
        chk("single noerr", 64'(err_sel), 64'(0));
      end else begin
        chk("single bad valid", 64'(out_valid), 64'(0));
        chk("single bad err",   64'(err_sel),   64'(1));
      end
    end
    @(posedge clk);
    #1;

    // packet lock: route taken from the first beat only
    for (int b = 0; b < 4; b++) begin
      send(lk[b], (b == 0) ? 3'd3 : 3'd5, b == 3, w);
      chk("lock valid", 64'(out_valid), 64'h08);
      chk("lock data",  64'(out_data[3*DW +: DW]), 64'(lk[b]));
      chk("lock last",  64'(out_last[3]), 64'(b == 3));
      chk("lock busy",  64'(busy), 64'(b != 3));
    end
    @(posedge clk);
    #1;

    // backpressure on channel 2 while channel 5 keeps flowing
    out_ready = 6'b111011;
    c0 = deliv[2];
    send(8'h5A, 3'd2, 1'b1, w);
    chk("bp first", 64'(out_data[2*DW +: DW]), 64'h5A);
    send(8'h61, 3'd5, 1'b0, w);
    send(8'h62, 3'd5, 1'b1, w);
    chk("bp other data", 64'(out_data[5*DW +: DW]), 64'h62);
    chk("bp other last", 64'(out_last[5]), 64'(1));
    chk("bp held valid", 64'(out_valid[2]), 64'(1));
    fork
      send(8'hA5, 3'd2, 1'b1, w);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp stall ready", 64'(in_ready), 64'(0));
        chk("bp hold data", 64'(out_data[2*DW +: DW]), 64'h5A);
        out_ready[2] = 1'b1;
      end
    join
    chk("bp stalled", 64'(w > 0), 64'(1));
    chk("bp second", 64'(out_data[2*DW +: DW]), 64'hA5);
    @(posedge clk);
    #1;
    chk("bp delivered", 64'(deliv[2] - c0), 64'(2));

    // full rate on channel 1
    out_ready = '1;
    c0 = deliv[1];
    tw = 0;
    for (int b = 0; b < 8; b++) begin
      send(8'(8'h30 + b), 3'd1, b == 7, w);
      tw += w;
      chk("full valid", 64'(out_valid[1]), 64'(1));
    end
    chk("full stalls", 64'(tw), 64'(0));
    @(posedge clk);
    #1;
    chk("full delivered", 64'(deliv[1] - c0), 64'(8));

    // invalid select drops the whole packet with one error pulse
    e0 = err_cnt;
    tw = 0;
    for (int b = 0; b < 3; b++) begin
      send(8'(b + 1), 3'd7, b == 2, w);
      tw += w;
      chk("inv no valid", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    chk("inv ready", 64'(tw), 64'(0));
    chk("inv err once", 64'(err_cnt - e0), 64'(1));
    send(8'h99, 3'd0, 1'b1, w);
    chk("inv next valid", 64'(out_valid), 64'h01);
    chk("inv next data", 64'(out_data[0 +: DW]), 64'h99);

    // asynchronous reset in the middle of a packet
    send(8'h41, 3'd4, 1'b0, w);
    send(8'h42, 3'd4, 1'b0, w);
    #2;
    rst = 1'b1;
    #1;
    chk("rst valid", 64'(out_valid), 64'(0));
    chk("rst busy",  64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h77, 3'd1, 1'b1, w);
    chk("rst next valid", 64'(out_valid), 64'h02);
    chk("rst next data", 64'(out_data[1*DW +: DW]), 64'h77);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      in_sel    = 3'($urandom_range(0, 7));
      in_last   = ($urandom % 3) == 0;
      out_ready = 6'($urandom | $urandom);
      if (k == 700) begin
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = '1;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
